// File: rtl/qam_demapper.sv
// qam_demapper: 16-QAM decision slicer and symbol demapper.
// Decimates the matched-filtered I/Q stream to one decision sample per symbol,
// slices each axis against the 16-QAM grid and queues the recovered 4-bit
// symbols in a small first-word-fall-through FIFO with registered outputs.
//
// Ports:
//   axi_clk, axi_rstn        clock, async active-low reset (synchronised release)
//   demult_valid/_i/_q       sample strobe and signed 5Q12 I/Q samples
//   dout_valid/dout/dout_ready  symbol output handshake; dout[3:2]=I, dout[1:0]=Q
//   overflow                 sticky: a symbol was dropped on a full FIFO
// Optional (define QAM_DEMAP_EVM_EN):
//   evm_clr                  clears the error statistics
//   evm_acc/evm_cnt          saturating error-magnitude sum / decision count
module qam_demapper #(
    parameter int unsigned SPS          = 8,
    parameter int unsigned SAMPLE_PHASE = 4,
    parameter int unsigned SKIP         = 16,
    parameter int unsigned LEVEL        = 4096,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               axi_clk,
    input  logic               axi_rstn,
    input  logic               demult_valid,
    input  logic signed [17:0] demult_i,
    input  logic signed [17:0] demult_q,
    output logic               dout_valid,
    output logic [3:0]         dout,
    input  logic               dout_ready,
    output logic               overflow
`ifdef QAM_DEMAP_EVM_EN
    ,
    input  logic               evm_clr,
    output logic [31:0]        evm_acc,
    output logic [15:0]        evm_cnt
`endif
);

    localparam int unsigned PH_W   = $clog2(SPS);
    localparam int unsigned SKIP_W = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic signed [17:0] THR_HI = 18'(2 * LEVEL);
    localparam logic signed [17:0] THR_LO = -THR_HI;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Per-axis decision; ties go to the upper region.
    function automatic logic [1:0] slice(input logic signed [17:0] x);
        if (x >= THR_HI)      return 2'b10;
        else if (!x[17])      return 2'b11;
        else if (x >= THR_LO) return 2'b01;
        else                  return 2'b00;
    endfunction

    // Reset: asynchronous assert, release synchronised to axi_clk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Acquisition / symbol-timing FSM.
    logic [1:0]        state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              take_c;

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        phase_d    = phase_q;
        take_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (demult_valid) begin
                    if (SKIP == 0) begin
                        // First sample is already RUN phase 0.
                        state_d = ST_RUN;
                        take_c  = (SAMPLE_PHASE == 0);
                        phase_d = PH_W'(1);
                    end else if (SKIP == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_ACQ;
                        skip_cnt_d = SKIP_W'(1);
                    end
                end
            end
            ST_ACQ: begin
                if (demult_valid) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q + SKIP_W'(1) == SKIP_W'(SKIP)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (demult_valid) begin
                    take_c  = (phase_q == PH_W'(SAMPLE_PHASE));
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered decision feeding the FIFO one cycle later.
    logic       dec_valid_q;
    logic [3:0] dec_sym_q;

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q <= 1'b0;
            dec_sym_q   <= '0;
        end else begin
            dec_valid_q <= take_c;
            if (take_c) dec_sym_q <= {slice(demult_i), slice(demult_q)};
        end
    end

    // FWFT FIFO; dout/dout_valid are registered copies of the next head.
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, count_after_pop;
    logic             pop_c, push_c, drop_c;
    logic             dout_valid_q, dout_valid_d;
    logic [3:0]       dout_q, dout_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        pop_c           = dout_valid_q && dout_ready;
        push_c          = dec_valid_q && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_c);
        drop_c          = dec_valid_q && !push_c;
        count_after_pop = count_q - CNT_W'(pop_c);
        count_d         = count_after_pop + CNT_W'(push_c);
        rd_ptr_d        = rd_ptr_q + PTR_W'(pop_c);
        dout_valid_d    = (count_d != '0);
        dout_d          = dout_q;
        // A push into an (effectively) empty FIFO bypasses straight to the head.
        if (push_c && count_after_pop == '0) dout_d = dec_sym_q;
        else if (count_after_pop != '0)      dout_d = mem_q[rd_ptr_d];
        overflow_d      = overflow_q | drop_c;
    end

    always_ff @(posedge axi_clk) begin
        if (push_c) mem_q[wr_ptr_q] <= dec_sym_q;
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign overflow   = overflow_q;

`ifdef QAM_DEMAP_EVM_EN
    localparam logic signed [18:0] LVL1 = 19'(LEVEL);
    localparam logic signed [18:0] LVL3 = 19'(3 * LEVEL);

    function automatic logic signed [18:0] ideal(input logic [1:0] b);
        case (b)
            2'b10:   return LVL3;
            2'b11:   return LVL1;
            2'b01:   return -LVL1;
            default: return -LVL3;
        endcase
    endfunction

    // |x - ideal(x)| in unsigned 5Q12.
    function automatic logic [18:0] axis_err(input logic signed [17:0] x);
        logic signed [18:0] diff;
        diff = {x[17], x} - ideal(slice(x));
        return diff[18] ? 19'(-diff) : 19'(diff);
    endfunction

    logic [31:0] evm_acc_q, evm_acc_d;
    logic [15:0] evm_cnt_q, evm_cnt_d;
    logic [19:0] err_c;
    logic [32:0] acc_sum_c;

    always_comb begin
        err_c     = 20'(axis_err(demult_i)) + 20'(axis_err(demult_q));
        acc_sum_c = {1'b0, evm_acc_q} + 33'(err_c);
        evm_acc_d = evm_acc_q;
        evm_cnt_d = evm_cnt_q;
        if (evm_clr) begin
            evm_acc_d = '0;
            evm_cnt_d = '0;
        end else if (take_c) begin
            evm_acc_d = acc_sum_c[32] ? 32'hFFFF_FFFF : acc_sum_c[31:0];
            evm_cnt_d = (evm_cnt_q == 16'hFFFF) ? evm_cnt_q : evm_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            evm_acc_q <= '0;
            evm_cnt_q <= '0;
        end else begin
            evm_acc_q <= evm_acc_d;
            evm_cnt_q <= evm_cnt_d;
        end
    end

    assign evm_acc = evm_acc_q;
    assign evm_cnt = evm_cnt_q;
`endif

endmodule
